// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift unit (SLL/SRL/SRA, optional ROR) with valid/ready on both sides.
// Define SHIFT_ROTATE_EN to make op 2'b11 a rotate-right; otherwise it is flagged illegal.
module shift_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_illegal
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // S1: latched operands
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q;
    logic [31:0]      s1_data_q;
    logic [4:0]       s1_shamt_q;
    logic [TAG_W-1:0] s1_tag_q;

    // S2: registered result
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_zero_q;
    logic             s2_illegal_q, s2_illegal_d;

    logic        s2_adv;
    logic        in_fire;
    logic [31:0] core_src;
    logic [31:0] core_hi;
    logic [31:0] core_out;

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // Single right-shift core: the upper half of the 64-bit window supplies the fill bits.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        core_src     = s1_data_q;
        core_hi      = 32'h0;
        s2_illegal_d = 1'b0;
        case (s1_op_q)
            OP_SLL: core_src = bit_rev(s1_data_q);
            OP_SRL: core_hi  = 32'h0;
            OP_SRA: core_hi  = {32{s1_data_q[31]}};
`ifdef SHIFT_ROTATE_EN
            default: core_hi = s1_data_q;
`else
            default: s2_illegal_d = 1'b1;
`endif
        endcase
        core_out = 32'({core_hi, core_src} >> s1_shamt_q);
    end

    always_comb begin
        s2_result_d = core_out;
        if (s2_illegal_d) begin
            s2_result_d = 32'h0;
        end else if (s1_op_q == OP_SLL) begin
            s2_result_d = bit_rev(core_out);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
        // Flush kills both stages, including an op accepted this same cycle.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 2'b00;
            s1_data_q  <= 32'h0;
            s1_shamt_q <= 5'd0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_op_q    <= in_op;
                s1_data_q  <= in_data;
                s1_shamt_q <= in_shamt;
                s1_tag_q   <= in_tag;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'h0;
            s2_tag_q     <= '0;
            s2_zero_q    <= 1'b1;
            s2_illegal_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_adv) begin
                s2_result_q  <= s2_result_d;
                s2_tag_q     <= s1_tag_q;
                s2_zero_q    <= (s2_result_d == 32'h0);
                s2_illegal_q <= s2_illegal_d;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_tag     = s2_tag_q;
    assign out_zero    = s2_zero_q;
    assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed sequences, a vector table and a
// randomized run scored against a queue-based arithmetic reference model.
module tb_shift_exec_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_zero;
    logic        out_illegal;

    shift_exec_stage #(.TAG_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_data     (in_data),
        .in_shamt    (in_shamt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [4:0]  tag;
        logic [31:0] exp_result;
        logic        exp_zero;
        logic        exp_illegal;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  tag;
        logic        zero;
        logic        illegal;
    } exp_t;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];

    logic        hold_pend;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;
    logic        hold_zero;
    logic        hold_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain shift arithmetic straight from the op definitions.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] d,
                                       input logic [4:0] s, input logic [4:0] tag);
        exp_t e;
        e.tag     = tag;
        e.illegal = 1'b0;
        case (op)
            2'b00:   e.result = d << s;
            2'b01:   e.result = d >> s;
            2'b10:   e.result = 32'($signed(d) >>> s);
            default: begin
`ifdef SHIFT_ROTATE_EN
                e.result = (d >> s) | (d << (32 - int'(s)));
`else
                e.result  = 32'h0;
                e.illegal = 1'b1;
`endif
            end
        endcase
        e.zero = (e.result == 32'h0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] s, input logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        in_tag   = tag;
    endtask

    // One scored cycle: inspect handshakes at the negedge, then advance past the posedge.
    task automatic monitor_cycle();
        exp_t e;
        @(negedge clock);
        if (hold_pend) begin
            check("hold_result", out_result, hold_res);
            check("hold_tag", 32'(out_tag), 32'(hold_tag));
            check("hold_flags", {30'd0, out_zero, out_illegal}, {30'd0, hold_zero, hold_ill});
        end
        hold_pend = out_valid && !out_ready && !flush;
        hold_res  = out_result;
        hold_tag  = out_tag;
        hold_zero = out_zero;
        hold_ill  = out_illegal;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_unexpected_output", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("rand_result", out_result, e.result);
                    check("rand_tag", 32'(out_tag), 32'(e.tag));
                    check("rand_flags", {30'd0, out_zero, out_illegal}, {30'd0, e.zero, e.illegal});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_model(in_op, in_data, in_shamt, in_tag));
            end
        end
        tick();
    endtask

    vec_t        vecs[7];
    vec_t        bp[3];
    logic [31:0] got_res[$];
    logic [4:0]  got_tag[$];

    initial begin
        int idx;
        int ghost;
        int budget;

        vecs[0] = '{2'b10, 32'h1234_5678, 5'd0,  5'd31, 32'h1234_5678, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 32'h0000_0001, 5'd31, 5'd5,  32'h8000_0000, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 5'd6,  32'h0000_0001, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 32'h8000_0000, 5'd31, 5'd7,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 32'h0000_FFFF, 5'd16, 5'd8,  32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
`ifdef SHIFT_ROTATE_EN
        vecs[6] = '{2'b11, 32'h0000_0001, 5'd1,  5'd9,  32'h8000_0000, 1'b0, 1'b0};
`else
        vecs[6] = '{2'b11, 32'h0000_0001, 5'd1,  5'd9,  32'h0000_0000, 1'b1, 1'b1};
`endif
        bp[0] = '{2'b01, 32'h0000_00F0, 5'd4, 5'd1, 32'h0000_000F, 1'b0, 1'b0};
        bp[1] = '{2'b00, 32'h0000_0003, 5'd4, 5'd2, 32'h0000_0030, 1'b0, 1'b0};
        bp[2] = '{2'b10, 32'hF000_0000, 5'd4, 5'd4, 32'hFF00_0000, 1'b0, 1'b0};

        // Reset state
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1; hold_pend = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        tick(); tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'h0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_flags", {30'd0, out_zero, out_illegal}, {30'd0, 1'b1, 1'b0});
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock); reset = 1'b1;
        tick();

        // Reset asserted mid-flight discards everything
        drive(1'b1, 2'b00, 32'h0000_00FF, 5'd1, 5'd20);
        tick();
        drive(1'b1, 2'b01, 32'h0000_00FF, 5'd1, 5'd21);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        #2 reset = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_result", out_result, 32'h0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock); reset = 1'b1;
        tick();
        check("postreset_no_output", 32'(out_valid), 32'd0);

        // First op after reset: latency of exactly two cycles
        drive(1'b1, 2'b01, 32'h0000_00F0, 5'd4, 5'd3);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        check("first_latency_not_early", 32'(out_valid), 32'd0);
        tick();
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_out_result", out_result, 32'h0000_000F);
        check("first_out_tag", 32'(out_tag), 32'd3);
        tick();

        // Streaming boundary shifts at full throughput
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd31, 5'd11);
        tick();
        drive(1'b1, 2'b10, 32'h8000_0000, 5'd31, 5'd12);
        tick();
        check("stream_v0", 32'(out_valid), 32'd1);
        check("stream_r0", out_result, 32'h8000_0000);
        drive(1'b1, 2'b01, 32'h8000_0000, 5'd31, 5'd13);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        check("stream_v1", 32'(out_valid), 32'd1);
        check("stream_r1", out_result, 32'hFFFF_FFFF);
        tick();
        check("stream_v2", 32'(out_valid), 32'd1);
        check("stream_r2", out_result, 32'h0000_0001);
        check("stream_t2", 32'(out_tag), 32'd13);
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: out_ready low for 4 cycles with 3 ops offered
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (idx < 3) drive(1'b1, bp[idx].op, bp[idx].data, bp[idx].shamt, bp[idx].tag);
            else         drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
            @(negedge clock);
            if (cyc >= 2) begin
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_frozen_result", out_result, bp[0].exp_result);
                check("bp_frozen_tag", 32'(out_tag), 32'(bp[0].tag));
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("bp_accepted_count", 32'(idx), 32'd2);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (idx < 3) drive(1'b1, bp[idx].op, bp[idx].data, bp[idx].shamt, bp[idx].tag);
            else         drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
            @(negedge clock);
            if (out_valid) begin
                got_res.push_back(out_result);
                got_tag.push_back(out_tag);
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("bp_drain_count", 32'(got_res.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_res.size()) begin
                check("bp_drain_result", got_res[i], bp[i].exp_result);
                check("bp_drain_tag", 32'(got_tag[i]), 32'(bp[i].tag));
            end
        end

        // Flush with both stages full and out_ready low, then flush over an accepted op
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h0000_0100, 5'd1, 5'd10);
        tick();
        drive(1'b1, 2'b01, 32'h0000_0200, 5'd1, 5'd14);
        tick();
        check("preflush_full", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
        flush = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_0400, 5'd1, 5'd15);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_0800, 5'd1, 5'd16);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        ghost = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clock);
            if (out_valid) ghost++;
            tick();
        end
        check("flush_no_ghost_outputs", 32'(ghost), 32'd0);

        // Vector table, one op at a time
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].tag);
            tick();
            drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
            check($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
            check($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vecs[i].exp_zero));
            check($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_illegal));
        end
        tick();

        // Randomized traffic with backpressure and occasional flush
        sb.delete();
        hold_pend = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = $urandom();
            case ($urandom_range(0, 5))
                0:       in_shamt = 5'd0;
                1:       in_shamt = 5'd31;
                default: in_shamt = 5'($urandom_range(0, 31));
            endcase
            in_tag    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            monitor_cycle();
        end
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            monitor_cycle();
            budget++;
        end
        check("rand_drain_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-stage pipelined shift execution unit for the execute stage of the RISC datapath.
- Accepts a shift micro-op (operand, shift amount, op code, destination tag) from issue over a valid/ready handshake.
- Performs SLL/SRL/SRA on a 32-bit right-shift core; logical left shifts use bit-reversal around that core.
- Delivers the registered result plus tag to writeback/bypass over a second valid/ready handshake, with full throughput and backpressure.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside the operation

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline kill from branch/exception logic
- in_valid  in  1  issue presents a shift op
- in_ready  out  1  stage can accept the op this cycle
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature)
- in_data  in  32  operand A
- in_shamt  in  5  shift amount, 0..31
- in_tag  in  TAG_W  destination register tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_result  out  32  shifted value
- out_tag  out  TAG_W  tag of out_result
- out_zero  out  1  out_result == 0
- out_illegal  out  1  op was 11 with ROR not compiled in

Behaviour:
- Reset (async, reset low): s1_valid=0, s2_valid=0, and all data/tag registers cleared. Outputs: out_valid=0, out_result=0, out_tag=0, out_zero=1, out_illegal=0, in_ready=1. Reset asserted mid-operation discards all in-flight ops with no partial output.
- Stage S1 (operand latch): registers op, data, shamt and tag on in_valid && in_ready.
- Stage S2 (result register):
  - SLL: reverse data, right-shift logically by shamt, reverse again.
  - SRL: zero fill.
  - SRA: fill with data[31].
  - Result, tag, zero flag and illegal flag are registered into S2.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready stays high.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_adv (combinational)
  - Back-to-back ops sustain one result per cycle.
- Hold: while out_valid && !out_ready, out_result, out_tag, out_zero and out_illegal stay stable. S1 holds its op; in_ready drops once S1 is occupied.
- Simultaneous output and input handshake in one cycle: S2 takes S1's op and S1 takes the new op. Nothing is lost or duplicated.
- flush (synchronous): clears s1_valid and s2_valid at the next edge, even if out_ready is low. An input handshake in the flush cycle is also discarded. in_ready=1 the cycle after a flush.
- Boundaries:
  - shamt=0 returns data unchanged for all ops.
  - shamt=31: SLL of 1 gives 0x80000000; SRA of 0x80000000 gives 0xFFFFFFFF; SRL of 0x80000000 gives 0x00000001.
- Width rules: shamt is an unsigned 5-bit value. No bits above 31 are kept.

Optional Feature:
- Macro: SHIFT_ROTATE_EN
- Defined: op 11 is rotate-right, result = (data >> shamt) | (data << (32-shamt)), with shamt=0 giving data. out_illegal is always 0.
- Undefined: op 11 flows through the pipeline with out_result=0, out_zero=1, out_illegal=1 for that result only. Tag and timing are unchanged.

Test Plan:
- Reset low with ops in flight, then release → out_valid=0, out_result=0, in_ready=1. First op after release (SRL 0x000000F0 by 4, tag 3) gives 0x0000000F, tag 3, 2 cycles later.
- Streaming SLL 0x00000001 by 31, SRA 0x80000000 by 31, SRL 0x80000000 by 31, out_ready=1 → results 0x80000000, 0xFFFFFFFF, 0x00000001 on consecutive cycles.
- out_ready held low 4 cycles with 3 ops offered → out_result frozen on the first result, in_ready=0 after S1 fills. Releasing out_ready drains the ops in order with no drops.
- flush asserted while S1 and S2 are valid and out_ready=0 → out_valid=0 next cycle, and the dropped tags never appear.
- op 11, data 0x00000001, shamt 1 → 0x80000000 with SHIFT_ROTATE_EN; otherwise result 0, out_zero=1, out_illegal=1.
- SRA 0x12345678 by 0, tag 31 → 0x12345678, out_zero=0, out_tag=31.
